// File: rtl/csr_pkg.sv
// Shared constants and state encoding for the machine-mode CSR trap sequencer.
package csr_pkg;

  localparam logic [2:0] CSR_IDX_MSTATUS  = 3'd0;
  localparam logic [2:0] CSR_IDX_MTVEC    = 3'd1;
  localparam logic [2:0] CSR_IDX_MSCRATCH = 3'd2;
  localparam logic [2:0] CSR_IDX_MEPC     = 3'd3;
  localparam logic [2:0] CSR_IDX_MCAUSE   = 3'd4;
  localparam logic [2:0] CSR_IDX_MTVAL    = 3'd5;
  localparam logic [2:0] CSR_IDX_INVALID  = 3'd6;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam logic [1:0]  MPP_MACHINE    = 2'b11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STATUS,
    S_RD_TVEC,
    S_M_STATUS,
    S_M_EPC,
    S_REDIRECT
  } csr_state_t;

endpackage

// File: rtl/trap_target_calc.sv
// Trap entry target: mtvec base, plus 4*code for vectored interrupts.
module trap_target_calc
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_cause,
  output logic [XLEN-1:0] o_target
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            w_vectored;
  logic [XLEN-1:0] w_code;
  logic [XLEN-1:0] w_offset;

  always_comb begin
    w_vectored = VECTORED_EN && (i_mtvec[1:0] == MTVEC_MODE_VECTORED) && i_cause[XLEN-1];
    w_code     = {1'b0, i_cause[XLEN-2:0]};
    // shifting out the top code bit gives the modulo-2^XLEN wrap for free
    w_offset   = w_vectored ? (w_code << 2) : '0;
    o_target   = (i_mtvec & ALIGN_MASK) + w_offset;
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Arbitrates the CSR file port between pipeline accesses, trap entry and mret.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  output logic            exc_ready,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  output logic            mret_ready,
  input  logic            csr_req_valid,
  input  logic            csr_req_we,
  input  logic [2:0]      csr_req_idx,
  input  logic [XLEN-1:0] csr_req_wdata,
  output logic            csr_req_ready,
  output logic [2:0]      csr_idx,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  csr_state_t      r_state;
  csr_state_t      w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_trap_target;

  trap_target_calc #(
    .XLEN        (XLEN),
    .VECTORED_EN (VECTORED_EN)
  ) u_target (
    .i_mtvec  (csr_rdata),
    .i_cause  (r_cause),
    .o_target (w_trap_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_cause  <= '0;
      r_tval   <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && exc_valid) begin
        r_pc    <= exc_pc & ALIGN_MASK;
        r_cause <= exc_cause;
        r_tval  <= exc_tval;
      end
      if (r_state == S_RD_TVEC) r_target <= w_trap_target;
      if (r_state == S_M_EPC)   r_target <= csr_rdata & ALIGN_MASK;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    exc_ready      = 1'b0;
    mret_ready     = 1'b0;
    csr_req_ready  = 1'b0;
    csr_idx        = CSR_IDX_MSTATUS;
    csr_we         = 1'b0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = r_target;
    busy           = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        exc_ready     = 1'b1;
        mret_ready    = !exc_valid;
        csr_req_ready = !exc_valid && !mret_valid;
        csr_idx       = csr_req_idx;
        csr_wdata     = csr_req_wdata;
        csr_we        = csr_req_valid && csr_req_we && csr_req_ready &&
                        (csr_req_idx != CSR_IDX_INVALID);
        if (exc_valid)       w_state_next = S_W_EPC;
        else if (mret_valid) w_state_next = S_M_STATUS;
      end
      S_W_EPC: begin
        csr_idx      = CSR_IDX_MEPC;
        csr_we       = 1'b1;
        csr_wdata    = r_pc;
        w_state_next = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_idx      = CSR_IDX_MCAUSE;
        csr_we       = 1'b1;
        csr_wdata    = r_cause;
        w_state_next = S_W_TVAL;
      end
      S_W_TVAL: begin
        csr_idx      = CSR_IDX_MTVAL;
        csr_we       = 1'b1;
        csr_wdata    = r_tval;
        w_state_next = S_W_STATUS;
      end
      S_W_STATUS: begin
        csr_idx                                  = CSR_IDX_MSTATUS;
        csr_we                                   = 1'b1;
        csr_wdata                                = csr_rdata;
        csr_wdata[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
        csr_wdata[MSTATUS_MIE]                   = 1'b0;
        csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_MACHINE;
        w_state_next                             = S_RD_TVEC;
      end
      S_RD_TVEC: begin
        csr_idx      = CSR_IDX_MTVEC;
        w_state_next = S_REDIRECT;
      end
      S_M_STATUS: begin
        csr_idx                                  = CSR_IDX_MSTATUS;
        csr_we                                   = 1'b1;
        csr_wdata                                = csr_rdata;
        csr_wdata[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
        csr_wdata[MSTATUS_MPIE]                  = 1'b1;
        csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_MACHINE;
        w_state_next                             = S_M_EPC;
      end
      S_M_EPC: begin
        csr_idx      = CSR_IDX_MEPC;
        w_state_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // reset must silence the port immediately, not one edge later
    if (rst) begin
      w_state_next   = S_IDLE;
      exc_ready      = 1'b0;
      mret_ready     = 1'b0;
      csr_req_ready  = 1'b0;
      csr_idx        = CSR_IDX_MSTATUS;
      csr_we         = 1'b0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Randomised self-checking bench: CSR file model plus a transaction-level reference.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_ready;
  logic [31:0] exc_pc, exc_cause, exc_tval;
  logic        mret_valid, mret_ready;
  logic        csr_req_valid, csr_req_we, csr_req_ready;
  logic [2:0]  csr_req_idx, csr_idx;
  logic [31:0] csr_req_wdata, csr_wdata, csr_rdata, redirect_pc;
  logic        csr_we, redirect_valid, busy;

  logic [31:0] csr_mem [0:7];
  logic [31:0] ref_mem [0:7];
  logic [2:0]  exp_idx [$];
  logic [31:0] exp_dat [$];
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  csr_trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_ready(exc_ready),
    .exc_pc(exc_pc), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .csr_req_valid(csr_req_valid), .csr_req_we(csr_req_we),
    .csr_req_idx(csr_req_idx), .csr_req_wdata(csr_req_wdata),
    .csr_req_ready(csr_req_ready),
    .csr_idx(csr_idx), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // CSR file: combinational read, write on the clock edge
  assign csr_rdata = (csr_idx < 3'd6) ? csr_mem[csr_idx] : 32'h0;
  always @(posedge clk) if (csr_we) csr_mem[csr_idx] <= csr_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] trap_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1800 | (s[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1880 | (s[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] t;
    t = tvec - (tvec % 4);
    if ((tvec % 4) == 1 && cause >= 32'h8000_0000) t = t + 4 * (cause - 32'h8000_0000);
    return t;
  endfunction

  task automatic model_exc(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, output logic [31:0] tgt);
    logic [31:0] st;
    st = trap_status(ref_mem[0]);
    exp_idx.push_back(3'd3); exp_dat.push_back(pc - (pc % 4));
    exp_idx.push_back(3'd4); exp_dat.push_back(cause);
    exp_idx.push_back(3'd5); exp_dat.push_back(tval);
    exp_idx.push_back(3'd0); exp_dat.push_back(st);
    ref_mem[3] = pc - (pc % 4); ref_mem[4] = cause; ref_mem[5] = tval; ref_mem[0] = st;
    tgt = trap_target(ref_mem[1], cause);
  endtask

  task automatic model_mret(output logic [31:0] tgt);
    logic [31:0] st;
    st = mret_status(ref_mem[0]);
    exp_idx.push_back(3'd0); exp_dat.push_back(st);
    ref_mem[0] = st;
    tgt = ref_mem[3] - (ref_mem[3] % 4);
  endtask

  // Watch nk cycles after acceptance; exp_k = cycle of the redirect pulse (0 = none)
  task automatic observe(input int unsigned nk, input int unsigned exp_k,
                         input logic [31:0] exp_pc, input int unsigned exp_busy);
    int unsigned nexp, nw, nbusy, nred, seen_k;
    logic [31:0] got_pc;
    nexp = exp_idx.size(); nw = 0; nbusy = 0; nred = 0; seen_k = 0; got_pc = 32'h0;
    for (int unsigned k = 1; k <= nk; k++) begin
      @(negedge clk); #1;
      if (busy) nbusy++;
      if (csr_we) begin
        nw++;
        if (exp_idx.size() > 0) begin
          check_eq("wr_idx", 32'(csr_idx), 32'(exp_idx.pop_front()));
          check_eq("wr_data", csr_wdata, exp_dat.pop_front());
        end
      end
      if (redirect_valid) begin
        nred++; seen_k = k; got_pc = redirect_pc;
      end
    end
    check_eq("wr_count", nw, nexp);
    check_eq("redir_count", nred, (exp_k != 0) ? 1 : 0);
    check_eq("redir_cycle", seen_k, exp_k);
    if (exp_k != 0) check_eq("redir_pc", got_pc, exp_pc);
    check_eq("busy_cycles", nbusy, exp_busy);
    check_eq("busy_end", 32'(busy), 32'h0);
    exp_idx.delete(); exp_dat.delete();
  endtask

  task automatic run_exc(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    logic [31:0] tgt;
    @(negedge clk);
    exc_valid = 1'b1; exc_pc = pc; exc_cause = cause; exc_tval = tval;
    #1;
    check_eq("exc_ready", 32'(exc_ready), 32'h1);
    model_exc(pc, cause, tval, tgt);
    @(posedge clk); #1;
    exc_valid = 1'b0;
    observe(7, 6, tgt, 6);
    check_eq("hold_rpc", redirect_pc, tgt);
  endtask

  task automatic run_mret();
    logic [31:0] tgt;
    @(negedge clk);
    mret_valid = 1'b1;
    #1;
    check_eq("mret_ready", 32'(mret_ready), 32'h1);
    model_mret(tgt);
    @(posedge clk); #1;
    mret_valid = 1'b0;
    observe(4, 3, tgt, 3);
  endtask

  task automatic pipe_op(input logic we, input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    csr_req_valid = 1'b1; csr_req_we = we; csr_req_idx = idx; csr_req_wdata = d;
    #1;
    check_eq("req_ready", 32'(csr_req_ready), 32'h1);
    check_eq("pipe_we", 32'(csr_we), (we && idx != 3'd6) ? 32'h1 : 32'h0);
    check_eq("pipe_idx", 32'(csr_idx), 32'(idx));
    if (we) check_eq("pipe_wdata", csr_wdata, d);
    else if (idx < 3'd6) check_eq("pipe_rdata", csr_rdata, ref_mem[idx]);
    if (we && idx != 3'd6) ref_mem[idx] = d;
    @(posedge clk); #1;
    csr_req_valid = 1'b0; csr_req_we = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt, c;
    int unsigned op;
    for (int i = 0; i < 8; i++) begin
      csr_mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    rst = 1'b1; exc_valid = 1'b0; mret_valid = 1'b0;
    exc_pc = 32'h0; exc_cause = 32'h0; exc_tval = 32'h0;
    csr_req_valid = 1'b0; csr_req_we = 1'b0; csr_req_idx = 3'd0; csr_req_wdata = 32'h0;
    exc_valid = 1'b1; mret_valid = 1'b1; csr_req_valid = 1'b1; csr_req_we = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_we", 32'(csr_we), 32'h0);
    check_eq("rst_redir", 32'(redirect_valid), 32'h0);
    check_eq("rst_rpc", redirect_pc, 32'h0);
    check_eq("rst_readies", {29'h0, exc_ready, mret_ready, csr_req_ready}, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    exc_valid = 1'b0; mret_valid = 1'b0; csr_req_valid = 1'b0; csr_req_we = 1'b0;
    rst = 1'b0;

    // trap entry, direct mode
    pipe_op(1'b1, 3'd0, 32'h0000_0008);
    pipe_op(1'b1, 3'd1, 32'h0000_0100);
    run_exc(32'h0000_2002, 32'd2, 32'h0000_DEAD);
    check_eq("mstatus_after_trap", csr_mem[0], 32'h0000_1880);

    // vectored interrupt versus synchronous exception
    pipe_op(1'b1, 3'd1, 32'h0000_0101);
    run_exc(32'h0000_4000, 32'h8000_0007, 32'h0);
    check_eq("vec_target", redirect_pc, 32'h0000_011C);
    run_exc(32'h0000_4000, 32'd5, 32'h0);
    check_eq("nonvec_target", redirect_pc, 32'h0000_0100);

    // mret
    pipe_op(1'b1, 3'd0, 32'h0000_1880);
    pipe_op(1'b1, 3'd3, 32'h0000_2000);
    run_mret();
    check_eq("mret_target", redirect_pc, 32'h0000_2000);
    check_eq("mstatus_after_mret", csr_mem[0], 32'h0000_1888);

    // invalid index write is dropped, valid one passes straight through
    pipe_op(1'b1, 3'd6, 32'h0000_0055);
    pipe_op(1'b1, 3'd2, 32'h0000_0055);
    pipe_op(1'b0, 3'd2, 32'h0);

    // all three requesters at once: exc, then mret, then the pipeline write
    @(negedge clk);
    exc_valid = 1'b1; exc_pc = 32'h0000_3006; exc_cause = 32'd11; exc_tval = 32'h1111;
    mret_valid = 1'b1;
    csr_req_valid = 1'b1; csr_req_we = 1'b1; csr_req_idx = 3'd2; csr_req_wdata = 32'h77;
    #1;
    check_eq("pri_exc_ready", 32'(exc_ready), 32'h1);
    check_eq("pri_mret_ready", 32'(mret_ready), 32'h0);
    check_eq("pri_req_ready", 32'(csr_req_ready), 32'h0);
    model_exc(32'h0000_3006, 32'd11, 32'h1111, tgt);
    @(posedge clk); #1;
    exc_valid = 1'b0;
    observe(7, 6, tgt, 6);
    check_eq("pri2_mret_ready", 32'(mret_ready), 32'h1);
    check_eq("pri2_req_ready", 32'(csr_req_ready), 32'h0);
    model_mret(tgt);
    exp_idx.push_back(3'd2); exp_dat.push_back(32'h77);
    ref_mem[2] = 32'h77;
    @(posedge clk); #1;
    mret_valid = 1'b0;
    observe(4, 3, tgt, 3);
    check_eq("pri3_req_ready", 32'(csr_req_ready), 32'h1);
    @(posedge clk); #1;
    csr_req_valid = 1'b0; csr_req_we = 1'b0;

    // reset in the middle of trap entry
    @(negedge clk);
    exc_valid = 1'b1; exc_pc = 32'h0000_5000; exc_cause = 32'd9; exc_tval = 32'h1234;
    #1;
    check_eq("rx_exc_ready", 32'(exc_ready), 32'h1);
    @(posedge clk); #1;
    exc_valid = 1'b0;
    ref_mem[3] = 32'h0000_5000; ref_mem[4] = 32'd9;
    @(negedge clk); #1;
    check_eq("rx_epc_idx", 32'(csr_idx), 32'd3);
    @(negedge clk); #1;
    check_eq("rx_cause_idx", 32'(csr_idx), 32'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rx_we_in_rst", 32'(csr_we), 32'h0);
    @(negedge clk); #1;
    check_eq("rx_outs", {27'h0, csr_we, redirect_valid, exc_ready, mret_ready, busy}, 32'h0);
    check_eq("rx_rpc", redirect_pc, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("rx_idle", 32'(exc_ready), 32'h1);
    observe(6, 0, 32'h0, 0);

    // randomised traffic against the reference
    for (int unsigned it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          c = ($urandom_range(0, 3) == 0) ? $urandom
                                          : ({$urandom_range(0, 1) == 1, 31'h0} | $urandom_range(0, 31));
          run_exc($urandom, c, $urandom);
        end
        1: run_mret();
        2: pipe_op(1'b1, 3'($urandom_range(0, 7)), $urandom);
        3: pipe_op(1'b0, 3'($urandom_range(0, 5)), 32'h0);
        default: pipe_op(1'b1, 3'd1, ($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 3));
      endcase
    end

    @(negedge clk);
    for (int i = 0; i < 6; i++) check_eq("final_csr", csr_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
